// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. It owns the fetch PC, issues
// back-to-back requests to instruction memory, keeps one spare instruction
// in a skid buffer while decode stalls, and squashes wrong-path fetches
// when the EX stage redirects the PC.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_DROP
    } state_e;

    // Low two bits are never meaningful for a word-aligned fetch address.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_RST     = RESET_PC & ALIGN_MASK;

    state_e      state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] pend_q,       pend_d;
    logic        out_vld_q,    out_vld_d;
    logic [31:0] out_pc_q,     out_pc_d;
    logic [31:0] out_instr_q,  out_instr_d;

    logic [31:0] redir_tgt;
    logic [31:0] pc_inc;
    logic        slot_free;

    assign redir_tgt = redirect_pc_i & ALIGN_MASK;
    assign pc_inc    = pc_q + 32'd4;
    // The IF/ID slot can take a new entry if it is empty or being consumed.
    assign slot_free = !out_vld_q || !stall_i;

    assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DROP);
    assign imem_addr_o = pc_q & ALIGN_MASK;
    assign pc_o        = pc_q;
    assign if_valid_o  = out_vld_q;
    assign if_pc_o     = out_pc_q;
    assign if_instr_o  = out_vld_q ? out_instr_q : NOP_INSTR;

    // State register and datapath registers; start_i low aborts everything.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_RST;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= 32'd0;
            pend_q       <= 32'd0;
            out_vld_q    <= 1'b0;
            out_pc_q     <= 32'd0;
            out_instr_q  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pend_q       <= pend_d;
            out_vld_q    <= out_vld_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    // Next-state logic: fetch sequencing, skid handling and redirect flush.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pend_d       = pend_q;
        out_vld_d    = out_vld_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;

        // A consumed entry disappears unless something new is loaded below.
        if (slot_free) begin
            out_vld_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (imem_ack_i && redirect_i) begin
                    // Returned word is on the wrong path; refetch at target.
                    pc_d = redir_tgt;
                end else if (imem_ack_i) begin
                    pc_d = pc_inc;
                    if (slot_free) begin
                        out_vld_d   = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = imem_rdata_i;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata_i;
                        state_d      = S_FULL;
                    end
                end else if (redirect_i) begin
                    // The request must complete at its original address
                    // before the target can be fetched.
                    pend_d  = redir_tgt;
                    state_d = S_DROP;
                end
            end

            S_FULL: begin
                if (redirect_i) begin
                    skid_pc_d    = 32'd0;
                    skid_instr_d = 32'd0;
                    pc_d         = redir_tgt;
                    state_d      = S_REQ;
                end else if (slot_free) begin
                    out_vld_d    = 1'b1;
                    out_pc_d     = skid_pc_q;
                    out_instr_d  = skid_instr_q;
                    skid_pc_d    = 32'd0;
                    skid_instr_d = 32'd0;
                    state_d      = S_REQ;
                end
            end

            S_DROP: begin
                if (imem_ack_i) begin
                    pc_d    = redirect_i ? redir_tgt : pend_q;
                    state_d = S_REQ;
                end else if (redirect_i) begin
                    pend_d = redir_tgt;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect flushes the IF/ID entry, overriding any stall hold.
        if (redirect_i) begin
            out_vld_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a latency-programmable
// instruction memory that returns addr ^ 32'hA5A5_0000.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        clk;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] pc;

    int unsigned lat;
    int unsigned wait_cnt;
    int          n_tests;
    int          n_fail;

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i         (clk),
        .start_i       (start),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_rdata_i  (imem_rdata),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_instr_o    (if_instr),
        .pc_o          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks once the request has been held for lat cycles.
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_addr ^ PAT;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        lat         = 0;
        wait_cnt    = 0;
        start       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Reset values
        tick(); tick();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_ifpc",  if_pc, 32'd0);
        check("rst_instr", if_instr, NOP);
        check("rst_pc",    pc, 32'd0);

        // Release: IDLE for one edge, then zero-wait streaming 0,4,8
        start = 1'b1;
        tick();
        check("first_req",   {31'd0, imem_req}, 32'd1);
        check("first_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("s0_valid", {31'd0, if_valid}, 32'd1);
        check("s0_pc",    if_pc, 32'h0);
        check("s0_instr", if_instr, 32'hA5A5_0000);
        tick();
        check("s1_pc",    if_pc, 32'h4);
        check("s1_instr", if_instr, 32'hA5A5_0004);
        tick();
        check("s2_pc",    if_pc, 32'h8);
        check("s2_valid", {31'd0, if_valid}, 32'd1);

        // Stall three edges while pc 8 is held; 12 goes to the skid
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",  if_pc, 32'h8);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_pco", pc, 32'h10);
        end
        stall = 1'b0;
        tick();
        check("unst_pc",    if_pc, 32'hC);
        check("unst_instr", if_instr, 32'hA5A5_000C);
        check("unst_addr",  imem_addr, 32'h10);
        tick();
        check("unst2_pc",   if_pc, 32'h10);
        check("unst2_vld",  {31'd0, if_valid}, 32'd1);

        // Redirect coinciding with ack while stalled: flush wins
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        tick();
        check("rack_valid", {31'd0, if_valid}, 32'd0);
        check("rack_instr", if_instr, NOP);
        check("rack_pc",    pc, 32'h10);
        redirect = 1'b0;
        stall    = 1'b0;
        lat      = 3;

        // Redirect to 0x100 while the 3-cycle fetch to 0x10 is outstanding
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("drop_addr",  imem_addr, 32'h10);
        check("drop_req",   {31'd0, imem_req}, 32'd1);
        check("drop_valid", {31'd0, if_valid}, 32'd0);
        tick();
        check("drop_ack",   {31'd0, imem_ack}, 32'd1);
        check("drop_addr2", imem_addr, 32'h10);
        tick();
        check("tgt_addr",   imem_addr, 32'h100);
        check("tgt_valid",  {31'd0, if_valid}, 32'd0);
        tick(); tick(); tick();
        check("tgt_wait",   {31'd0, if_valid}, 32'd0);
        tick();
        check("tgt_valid2", {31'd0, if_valid}, 32'd1);
        check("tgt_pc",     if_pc, 32'h100);
        check("tgt_instr",  if_instr, 32'hA5A5_0100);

        // Two redirects during one outstanding fetch: only 0x300 is fetched
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        check("dbl_valid", {31'd0, if_valid}, 32'd0);
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        check("dbl_addr",  imem_addr, 32'h104);
        tick(); tick();
        check("dbl_tgt",   imem_addr, 32'h300);
        check("dbl_vld0",  {31'd0, if_valid}, 32'd0);
        tick(); tick(); tick(); tick();
        check("dbl_pc",    if_pc, 32'h300);
        check("dbl_instr", if_instr, 32'hA5A5_0300);

        // Reset asserted mid-request aborts immediately
        tick();
        start = 1'b0;
        #1;
        check("mid_req",   {31'd0, imem_req}, 32'd0);
        check("mid_pc",    pc, 32'd0);
        check("mid_addr",  imem_addr, 32'd0);
        check("mid_valid", {31'd0, if_valid}, 32'd0);
        check("mid_instr", if_instr, NOP);
        lat = 0;
        tick();
        start = 1'b1;
        tick();
        check("re_req",  {31'd0, imem_req}, 32'd1);
        check("re_addr", imem_addr, 32'd0);
        tick();
        check("re_pc0",  if_pc, 32'h0);
        tick();
        check("re_pc1",  if_pc, 32'h4);

        // Unaligned target is forced aligned; pc wraps past 0xFFFF_FFFC
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        check("wrap_pc",   pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_ifpc",  if_pc, 32'hFFFF_FFFC);
        check("wrap_instr", if_instr, 32'h5A5A_FFFC);
        check("wrap_next",  pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
